// File: rtl/dp_sched_pkg.sv
// Shared types and encodings for the DP split-loop sequencer.
package dp_sched_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_NTT_KICK  = 3'd1,
        ST_NTT_WAIT  = 3'd2,
        ST_MADD_KICK = 3'd3,
        ST_MADD_WAIT = 3'd4,
        ST_NEXT      = 3'd5,
        ST_DONE      = 3'd6
    } dp_state_e;

    localparam logic [1:0] DP_MODE_NTT_MADD = 2'd0;
    localparam logic [1:0] DP_MODE_NTT      = 2'd1;
    localparam logic [1:0] DP_MODE_MADD     = 2'd2;

    localparam logic [2:0] ERR_NONE     = 3'd0;
    localparam logic [2:0] ERR_MODE     = 3'd1;
    localparam logic [2:0] ERR_SPURIOUS = 3'd2;
    localparam logic [2:0] ERR_DUP      = 3'd3;
    localparam logic [2:0] ERR_TIMEOUT  = 3'd4;
    localparam logic [2:0] ERR_ABORT    = 3'd5;

endpackage

// File: rtl/dp_done_collect.sv
// Sticky collector for per-core NTT done pulses with duplicate detection.
module dp_done_collect #(
    parameter int NUM_POLY = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_clr,
    input  logic                i_en,
    input  logic [NUM_POLY-1:0] i_done,
    output logic                o_all_done,
    output logic                o_dup
);

    logic [NUM_POLY-1:0] mask_q, mask_d;

    always_comb begin
        mask_d = mask_q;
        if (i_clr)
            mask_d = '0;
        else if (i_en)
            mask_d = mask_q | i_done;
    end

    always_ff @(posedge clk) begin
        if (rst)
            mask_q <= '0;
        else
            mask_q <= mask_d;
    end

    // All-done includes this cycle's pulses so the phase can exit without an extra cycle.
    assign o_all_done = i_en && (&(mask_q | i_done));
    assign o_dup      = i_en && (|(mask_q & i_done));

endmodule

// File: rtl/dp_sched.sv
// Split-loop sequencer driving NUM_POLY NTT cores and one multiply-add unit.
module dp_sched
    import dp_sched_pkg::*;
#(
    parameter int NUM_POLY    = 3,
    parameter int NUM_SPLIT   = 4,
    parameter int SPLIT_WIDTH = 2,
    parameter int TMO_WIDTH   = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_start,
    input  logic [1:0]             i_mode,
    input  logic [SPLIT_WIDTH-1:0] i_last_split,
    input  logic [TMO_WIDTH-1:0]   i_tmo_limit,
    input  logic                   i_abort,
    output logic                   o_busy,
    output logic                   o_done,
    output logic                   o_err,
    output logic [2:0]             o_err_code,
    output logic                   o_ntt_start,
    input  logic [NUM_POLY-1:0]    i_ntt_done,
    output logic                   o_madd_start,
    input  logic                   i_madd_done,
    output logic [SPLIT_WIDTH-1:0] o_idx_split
);

    dp_state_e              state_q, state_d;
    logic [1:0]             mode_q, mode_d;
    logic [SPLIT_WIDTH-1:0] last_q, last_d;
    logic [SPLIT_WIDTH-1:0] idx_q, idx_d;
    logic [TMO_WIDTH-1:0]   tmo_q, tmo_d;
    logic [TMO_WIDTH-1:0]   wdog_q, wdog_d;
    logic                   err_q, err_d;
    logic [2:0]             code_q, code_d;

    logic in_ntt_wait, in_madd_wait, active;
    logic all_done, dup, spurious, timeout;
    logic [TMO_WIDTH-1:0] wdog_inc;

    assign in_ntt_wait  = (state_q == ST_NTT_WAIT);
    assign in_madd_wait = (state_q == ST_MADD_WAIT);
    // DONE is excluded: it always returns to IDLE and must not overwrite the recorded code.
    assign active       = (state_q != ST_IDLE) && (state_q != ST_DONE);
    assign spurious     = active && (((|i_ntt_done) && !in_ntt_wait) ||
                                     (i_madd_done && !in_madd_wait));
    assign timeout      = (in_ntt_wait || in_madd_wait) && (tmo_q != '0) && (wdog_q >= tmo_q);
    assign wdog_inc     = (&wdog_q) ? wdog_q : wdog_q + 1'b1;

    dp_done_collect #(.NUM_POLY(NUM_POLY)) u_collect (
        .clk        (clk),
        .rst        (rst),
        .i_clr      (state_q == ST_NTT_KICK),
        .i_en       (in_ntt_wait),
        .i_done     (i_ntt_done),
        .o_all_done (all_done),
        .o_dup      (dup)
    );

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        last_d  = last_q;
        idx_d   = idx_q;
        tmo_d   = tmo_q;
        wdog_d  = wdog_q;
        err_d   = err_q;
        code_d  = code_q;
        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    mode_d = i_mode;
                    last_d = i_last_split;
                    tmo_d  = i_tmo_limit;
                    err_d  = 1'b0;
                    code_d = ERR_NONE;
                    case (i_mode)
                        DP_MODE_NTT_MADD, DP_MODE_NTT: state_d = ST_NTT_KICK;
                        DP_MODE_MADD:                  state_d = ST_MADD_KICK;
                        default: begin
                            state_d = ST_DONE;
                            err_d   = 1'b1;
                            code_d  = ERR_MODE;
                        end
                    endcase
                end
            end
            ST_NTT_KICK: begin
                wdog_d  = '0;
                state_d = ST_NTT_WAIT;
            end
            ST_NTT_WAIT: begin
                wdog_d = wdog_inc;
                if (all_done)
                    state_d = (mode_q == DP_MODE_NTT_MADD) ? ST_MADD_KICK : ST_NEXT;
            end
            ST_MADD_KICK: begin
                wdog_d  = '0;
                state_d = ST_MADD_WAIT;
            end
            ST_MADD_WAIT: begin
                wdog_d = wdog_inc;
                if (i_madd_done)
                    state_d = ST_NEXT;
            end
            ST_NEXT: begin
                if (idx_q == last_q) begin
                    state_d = ST_DONE;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = (mode_q == DP_MODE_MADD) ? ST_MADD_KICK : ST_NTT_KICK;
                end
            end
            ST_DONE: begin
                idx_d   = '0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Error overrides, highest priority first; only one code is ever recorded.
        if (active && (i_abort || dup || spurious || timeout)) begin
            state_d = ST_DONE;
            err_d   = 1'b1;
            if (i_abort)       code_d = ERR_ABORT;
            else if (dup)      code_d = ERR_DUP;
            else if (spurious) code_d = ERR_SPURIOUS;
            else               code_d = ERR_TIMEOUT;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            mode_q  <= DP_MODE_NTT_MADD;
            last_q  <= '0;
            idx_q   <= '0;
            tmo_q   <= '0;
            wdog_q  <= '0;
            err_q   <= 1'b0;
            code_q  <= ERR_NONE;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            last_q  <= last_d;
            idx_q   <= idx_d;
            tmo_q   <= tmo_d;
            wdog_q  <= wdog_d;
            err_q   <= err_d;
            code_q  <= code_d;
        end
    end

    assign o_busy       = (state_q != ST_IDLE);
    assign o_done       = (state_q == ST_DONE);
    assign o_ntt_start  = (state_q == ST_NTT_KICK);
    assign o_madd_start = (state_q == ST_MADD_KICK);
    assign o_err        = err_q;
    assign o_err_code   = code_q;
    assign o_idx_split  = idx_q;

endmodule

// File: tb/tb_dp_sched.sv
// Directed bench for dp_sched: table of whole runs plus hand-written corner sequences.
module tb_dp_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_start;
    logic [1:0]  i_mode;
    logic [1:0]  i_last_split;
    logic [15:0] i_tmo_limit;
    logic        i_abort;
    logic        o_busy, o_done, o_err, o_ntt_start, o_madd_start;
    logic [2:0]  o_err_code;
    logic [2:0]  i_ntt_done;
    logic        i_madd_done;
    logic [1:0]  o_idx_split;

    int total = 0;
    int bad   = 0;
    logic pn, pm;

    always #5 clk = ~clk;

    dp_sched #(.NUM_POLY(3), .NUM_SPLIT(4), .SPLIT_WIDTH(2), .TMO_WIDTH(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .i_start      (i_start),
        .i_mode       (i_mode),
        .i_last_split (i_last_split),
        .i_tmo_limit  (i_tmo_limit),
        .i_abort      (i_abort),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_err        (o_err),
        .o_err_code   (o_err_code),
        .o_ntt_start  (o_ntt_start),
        .i_ntt_done   (i_ntt_done),
        .o_madd_start (o_madd_start),
        .i_madd_done  (i_madd_done),
        .o_idx_split  (o_idx_split)
    );

    // delays are cycles after the kick; -1 withholds the pulse, 0 lands in the kick cycle
    typedef struct {
        logic [1:0]  mode;
        logic [1:0]  ls;
        logic [15:0] tmo;
        int d0, d1, d2, dm;
        int exp_done, exp_err, exp_code, exp_ntt, exp_madd, exp_seq;
    } vec_t;

    vec_t vt[12];

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // zero-latency engines: every done pulse arrives the cycle after its kick
    task automatic step();
        i_ntt_done  = {3{pn}};
        i_madd_done = pm;
        pn = o_ntt_start;
        pm = o_madd_start;
        tick();
    endtask

    task automatic start_run(input logic [1:0] mode, input logic [1:0] ls, input logic [15:0] tmo);
        i_mode = mode; i_last_split = ls; i_tmo_limit = tmo;
        i_start = 1'b1; pn = 1'b0; pm = 1'b0;
        tick();
        i_start = 1'b0;
    endtask

    task automatic run(input vec_t v, output int done_c, output int err, output int code,
                       output int n_ntt, output int n_madd, output int seq, output int busy_after);
        int kn, km;
        kn = -100; km = -100; done_c = -1; err = -1; code = -1;
        n_ntt = 0; n_madd = 0; seq = 0;
        start_run(v.mode, v.ls, v.tmo);
        for (int c = 1; c <= 100; c++) begin
            if (o_ntt_start) begin
                kn = c; n_ntt++;
                seq = seq * 4 + int'(o_idx_split);
            end
            if (o_madd_start) begin
                km = c; n_madd++;
                if (v.mode == 2'd2) seq = seq * 4 + int'(o_idx_split);
            end
            i_ntt_done[0] = (v.d0 >= 0) && (c == kn + v.d0);
            i_ntt_done[1] = (v.d1 >= 0) && (c == kn + v.d1);
            i_ntt_done[2] = (v.d2 >= 0) && (c == kn + v.d2);
            i_madd_done   = (v.dm >= 0) && (c == km + v.dm);
            if (o_done) begin
                done_c = c; err = int'(o_err); code = int'(o_err_code);
                break;
            end
            tick();
        end
        i_ntt_done = '0; i_madd_done = 1'b0;
        tick();
        busy_after = int'(o_busy);
    endtask

    initial begin
        int dc, er, cd, nn, nm, sq, ba, nd;
        bit hit;

        vt[0]  = '{2'd0, 2'd3, 16'd0,      1, 1, 1, 1,  21, 0, 0, 4, 4, 27};
        vt[1]  = '{2'd0, 2'd0, 16'd0,      1, 1, 1, 1,   6, 0, 0, 1, 1, 0};
        vt[2]  = '{2'd1, 2'd2, 16'd0,      1, 1, 1, 1,  10, 0, 0, 3, 0, 6};
        vt[3]  = '{2'd2, 2'd1, 16'd0,      1, 1, 1, 1,   7, 0, 0, 0, 2, 1};
        vt[4]  = '{2'd3, 2'd2, 16'd0,      1, 1, 1, 1,   1, 1, 1, 0, 0, 0};
        vt[5]  = '{2'd1, 2'd0, 16'd0,      4, 1, 9, 1,  12, 0, 0, 1, 0, 0};
        vt[6]  = '{2'd0, 2'd1, 16'd0,      4, 1, 9, 1,  27, 0, 0, 2, 2, 1};
        vt[7]  = '{2'd2, 2'd0, 16'd10,     1, 1, 1, -1, 13, 1, 4, 0, 1, 0};
        vt[8]  = '{2'd1, 2'd0, 16'd5,      1, 1, -1, 1,  8, 1, 4, 1, 0, 0};
        vt[9]  = '{2'd2, 2'd3, 16'hFFFF,   1, 1, 1, 1,  13, 0, 0, 0, 4, 27};
        vt[10] = '{2'd2, 2'd0, 16'd0,      1, 1, 1, 0,   2, 1, 2, 0, 1, 0};
        vt[11] = '{2'd1, 2'd0, 16'd0,      1, 1, 0, 1,   2, 1, 2, 1, 0, 0};

        rst = 1'b1; i_start = 1'b0; i_mode = '0; i_last_split = '0; i_tmo_limit = '0;
        i_abort = 1'b0; i_ntt_done = '0; i_madd_done = 1'b0; pn = 1'b0; pm = 1'b0;
        tick(); tick();
        chk("reset_outputs", int'({o_busy, o_done, o_err, o_err_code, o_ntt_start,
                                   o_madd_start, o_idx_split}), 0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 12; i++) begin
            run(vt[i], dc, er, cd, nn, nm, sq, ba);
            chk($sformatf("v%0d_done_cycle", i), dc, vt[i].exp_done);
            chk($sformatf("v%0d_err", i),        er, vt[i].exp_err);
            chk($sformatf("v%0d_code", i),       cd, vt[i].exp_code);
            chk($sformatf("v%0d_ntt_kicks", i),  nn, vt[i].exp_ntt);
            chk($sformatf("v%0d_madd_kicks", i), nm, vt[i].exp_madd);
            chk($sformatf("v%0d_idx_seq", i),    sq, vt[i].exp_seq);
            chk($sformatf("v%0d_busy_after", i), ba, 0);
            chk($sformatf("v%0d_idx_after", i),  int'(o_idx_split), 0);
        end

        // duplicate: core 1 pulses twice in one NTT_WAIT
        start_run(2'd1, 2'd0, 16'd0);
        tick();
        i_ntt_done = 3'b010; tick();
        i_ntt_done = 3'b010; tick();
        i_ntt_done = 3'b000;
        chk("dup_done", int'(o_done), 1);
        chk("dup_code", int'(o_err_code), 3);
        nd = 0;
        for (int c = 0; c < 6; c++) begin
            nd += int'(o_done);
            tick();
        end
        chk("dup_done_count", nd, 1);
        chk("dup_err_held", int'(o_err), 1);

        // abort in NTT_WAIT of split 2, then a clean run
        start_run(2'd0, 2'd3, 16'd0);
        hit = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (o_ntt_start && o_idx_split == 2'd2) begin
                hit = 1'b1;
                break;
            end
            step();
        end
        chk("abort_reached_split2", int'(hit), 1);
        step();
        i_abort = 1'b1; i_ntt_done = '0; i_madd_done = 1'b0; pn = 1'b0; pm = 1'b0;
        tick();
        i_abort = 1'b0;
        chk("abort_done", int'(o_done), 1);
        chk("abort_code", int'(o_err_code), 5);
        tick();
        chk("abort_idx_after", int'(o_idx_split), 0);
        chk("abort_busy_after", int'(o_busy), 0);
        run(vt[1], dc, er, cd, nn, nm, sq, ba);
        chk("post_abort_done_cycle", dc, 6);
        chk("post_abort_err", er, 0);
        chk("post_abort_code", cd, 0);

        // limit 0: MADD done withheld, block must wait indefinitely
        start_run(2'd2, 2'd0, 16'd0);
        nd = 0;
        for (int c = 0; c < 80; c++) begin
            nd += int'(o_done);
            tick();
        end
        chk("nolimit_no_done", nd, 0);
        chk("nolimit_busy", int'(o_busy), 1);
        i_abort = 1'b1; tick(); i_abort = 1'b0;
        chk("nolimit_abort_code", int'(o_err_code), 5);
        tick();
        chk("nolimit_idle", int'(o_busy), 0);

        // reset mid-run in split 1
        start_run(2'd0, 2'd3, 16'd0);
        for (int c = 0; c < 7; c++) step();
        chk("midrst_idx_before", int'(o_idx_split), 1);
        rst = 1'b1; i_ntt_done = '0; i_madd_done = 1'b0;
        tick();
        rst = 1'b0;
        chk("midrst_outputs", int'({o_busy, o_done, o_err, o_err_code, o_ntt_start,
                                    o_madd_start, o_idx_split}), 0);
        nd = 0;
        for (int c = 0; c < 10; c++) begin
            nd += int'(o_done) + int'(o_busy);
            tick();
        end
        chk("midrst_quiet", nd, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
